// File: rtl/fifo_rd_packer_if.sv
// Bus bundle between the async FIFO read port, the packer and the next stage.
// Optional macro FIFO_RD_PACKER_FLUSH_EN adds the flush request and out_cnt.
// The master modport is the packer side; the slave modport is the
// environment (FIFO plus downstream consumer).
interface fifo_rd_packer_if #(
  parameter int MEMORY_WIDTH = 4,
  parameter int PACK_RATIO   = 4
);
  localparam int OUT_WIDTH = MEMORY_WIDTH * PACK_RATIO;
  localparam int CNT_W     = $clog2(PACK_RATIO + 1);

  logic                    r_empty;
  logic [MEMORY_WIDTH-1:0] rdata;
  logic                    r_en;
  logic [OUT_WIDTH-1:0]    out_data;
  logic                    out_valid;
  logic                    out_ready;
`ifdef FIFO_RD_PACKER_FLUSH_EN
  logic                    flush;
  logic [CNT_W-1:0]        out_cnt;

  modport master (
    input  r_empty, rdata, out_ready, flush,
    output r_en, out_data, out_valid, out_cnt
  );

  modport slave (
    output r_empty, rdata, out_ready, flush,
    input  r_en, out_data, out_valid, out_cnt
  );
`else
  modport master (
    input  r_empty, rdata, out_ready,
    output r_en, out_data, out_valid
  );

  modport slave (
    output r_empty, rdata, out_ready,
    input  r_en, out_data, out_valid
  );
`endif
endinterface

// File: rtl/fifo_rd_packer.sv
// Read-side FIFO consumer: pops MEMORY_WIDTH-bit entries and packs
// PACK_RATIO of them (first entry in the low slot) into one wide word,
// presented on a valid/ready output with one word of double buffering.
// Optional macro FIFO_RD_PACKER_FLUSH_EN adds a flush request that emits a
// zero-padded partial word and reports the filled slot count on out_cnt.
module fifo_rd_packer #(
  parameter int MEMORY_WIDTH = 4,
  parameter int PACK_RATIO   = 4
) (
  input logic              r_clk,
  input logic              rrst_n,
  fifo_rd_packer_if.master bus
);
  localparam int OUT_WIDTH = MEMORY_WIDTH * PACK_RATIO;
  localparam int CNT_W     = $clog2(PACK_RATIO + 1);
  localparam int IDX_W     = $clog2(PACK_RATIO);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(PACK_RATIO);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PACK_RATIO - 1);

  typedef enum logic [0:0] {FILL, DONE} state_t;

  state_t               state;
  logic [CNT_W-1:0]     slot_cnt;
  logic                 in_flight;
  logic [IDX_W-1:0]     flight_idx;
  logic [OUT_WIDTH-1:0] acc;
  logic [OUT_WIDTH-1:0] acc_merged;
  logic [OUT_WIDTH-1:0] out_reg;
  logic                 out_valid_q;
  logic                 out_free;
  logic                 last_capture;
  logic                 flush_block;
  logic                 pop;

`ifdef FIFO_RD_PACKER_FLUSH_EN
  logic                 flush_pend;
  logic                 flush_take;
  logic [CNT_W-1:0]     out_cnt_q;

  // A flush only counts when the accumulator holds a genuine partial word.
  assign flush_take  = bus.flush && (state == FILL) &&
                       (slot_cnt != '0) && (slot_cnt < FULL_CNT);
  assign flush_block = flush_take || flush_pend;
  assign bus.out_cnt = out_cnt_q;
`else
  assign flush_block = 1'b0;
`endif

  // The output register can take a new word when empty or drained this cycle.
  assign out_free     = !out_valid_q || bus.out_ready;
  assign last_capture = in_flight && (flight_idx == LAST_IDX);

  // The slot counter already includes an in-flight pop, so it alone bounds popping.
  assign pop = rrst_n && !bus.r_empty && (state == FILL) &&
               (slot_cnt < FULL_CNT) && !flush_block;

  assign bus.r_en      = pop;
  assign bus.out_data  = out_reg;
  assign bus.out_valid = out_valid_q;

  // Accumulator view with the data returning this cycle already dropped into its slot.
  always_comb begin
    acc_merged = acc;
    if (in_flight) begin
      acc_merged[int'(flight_idx) * MEMORY_WIDTH +: MEMORY_WIDTH] = bus.rdata;
    end
  end

  // Slot bookkeeping, capture, FILL/DONE sequencing and output register load.
  always_ff @(posedge r_clk) begin
    if (!rrst_n) begin
      state       <= FILL;
      slot_cnt    <= '0;
      in_flight   <= 1'b0;
      flight_idx  <= '0;
      acc         <= '0;
      out_reg     <= '0;
      out_valid_q <= 1'b0;
`ifdef FIFO_RD_PACKER_FLUSH_EN
      flush_pend  <= 1'b0;
      out_cnt_q   <= '0;
`endif
    end else begin
      if (out_valid_q && bus.out_ready) begin
        out_valid_q <= 1'b0;
      end

      in_flight <= pop;
      if (pop) begin
        flight_idx <= slot_cnt[IDX_W-1:0];
        slot_cnt   <= slot_cnt + 1'b1;
      end

      if (in_flight) begin
        acc <= acc_merged;
      end

      case (state)
        FILL: begin
          if (last_capture) begin
            if (out_free) begin
              out_reg     <= acc_merged;
              out_valid_q <= 1'b1;
              acc         <= '0;
              slot_cnt    <= '0;
`ifdef FIFO_RD_PACKER_FLUSH_EN
              out_cnt_q   <= FULL_CNT;
`endif
            end else begin
              state <= DONE;
            end
          end
`ifdef FIFO_RD_PACKER_FLUSH_EN
          else if (flush_pend && !in_flight && out_free) begin
            out_reg     <= acc;
            out_valid_q <= 1'b1;
            out_cnt_q   <= slot_cnt;
            acc         <= '0;
            slot_cnt    <= '0;
            flush_pend  <= 1'b0;
          end else if (flush_take) begin
            flush_pend <= 1'b1;
          end
`endif
        end
        DONE: begin
          if (out_free) begin
            out_reg     <= acc;
            out_valid_q <= 1'b1;
            acc         <= '0;
            slot_cnt    <= '0;
            state       <= FILL;
`ifdef FIFO_RD_PACKER_FLUSH_EN
            out_cnt_q   <= FULL_CNT;
`endif
          end
        end
        default: state <= FILL;
      endcase
    end
  end
endmodule

// File: tb/tb_fifo_rd_packer.sv
// Self-checking bench for fifo_rd_packer: a queue models the async FIFO,
// a scoreboard of expected packed words is filled as entries are written
// and drained as the packer hands words downstream.
module tb_fifo_rd_packer;
  localparam int MEMORY_WIDTH = 4;
  localparam int PACK_RATIO   = 4;
  localparam int OUT_WIDTH    = MEMORY_WIDTH * PACK_RATIO;

  typedef struct {
    logic [OUT_WIDTH-1:0] data;
    int                   cnt;
  } exp_t;

  typedef struct {
    int n;
    int first;
    bit ready;
    int exp_words;
    int exp_pops;
    bit exp_valid;
  } vec_t;

  logic r_clk = 1'b0;
  logic rrst_n;

  fifo_rd_packer_if #(.MEMORY_WIDTH(MEMORY_WIDTH), .PACK_RATIO(PACK_RATIO)) bus ();

  fifo_rd_packer #(.MEMORY_WIDTH(MEMORY_WIDTH), .PACK_RATIO(PACK_RATIO)) dut (
    .r_clk  (r_clk),
    .rrst_n (rrst_n),
    .bus    (bus)
  );

  always #5 r_clk = ~r_clk;

  logic [MEMORY_WIDTH-1:0] fifo_q[$];
  exp_t                    exp_q[$];
  int                      accept_cycles[$];
  logic [OUT_WIDTH-1:0]    nib_buf = '0;
  int                      nib_cnt = 0;
  int                      checks = 0;
  int                      failures = 0;
  int                      cyc = 0;
  int                      pop_count = 0;
  int                      accept_count = 0;
  bit                      check_pulse = 1'b0;
  bit                      prev_accept = 1'b0;

  task automatic checkVal(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%0h required=0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Write one entry into the FIFO model and extend the expected word.
  task automatic pushFifo(input logic [MEMORY_WIDTH-1:0] nib);
    exp_t e;
    fifo_q.push_back(nib);
    bus.r_empty = 1'b0;
    nib_buf[nib_cnt * MEMORY_WIDTH +: MEMORY_WIDTH] = nib;
    nib_cnt++;
    if (nib_cnt == PACK_RATIO) begin
      e.data = nib_buf;
      e.cnt  = PACK_RATIO;
      exp_q.push_back(e);
      nib_buf = '0;
      nib_cnt = 0;
    end
  endtask

  // Sampled at the falling edge: protocol check and scoreboard comparison.
  task automatic checkOutput();
    checkVal("ren_while_empty", 64'(bus.r_en && bus.r_empty), 64'd0);
    if (check_pulse && prev_accept) begin
      checkVal("valid_one_cycle", 64'(bus.out_valid), 64'd0);
    end
    if (rrst_n && bus.out_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("[TB] FAIL unexpected_word actual=0x%0h required=none (cycle %0d)", bus.out_data, cyc);
      end else begin
        checkVal("out_data", 64'(bus.out_data), 64'(exp_q[0].data));
`ifdef FIFO_RD_PACKER_FLUSH_EN
        checkVal("out_cnt", 64'(bus.out_cnt), 64'(exp_q[0].cnt));
`endif
        if (bus.out_ready) begin
          void'(exp_q.pop_front());
          accept_count++;
          accept_cycles.push_back(cyc);
        end
      end
    end
    prev_accept = rrst_n && bus.out_valid && bus.out_ready;
  endtask

  // One clock: check at negedge, then let the FIFO model answer a pop after posedge.
  task automatic stepCycle();
    bit popped;
    @(negedge r_clk);
    checkOutput();
    popped = bus.r_en && !bus.r_empty;
    @(posedge r_clk);
    #1;
    cyc++;
    if (popped && fifo_q.size() > 0) begin
      bus.rdata = fifo_q.pop_front();
      pop_count++;
    end
    bus.r_empty = (fifo_q.size() == 0);
  endtask

  task automatic runCycles(input int n);
    for (int i = 0; i < n; i++) stepCycle();
  endtask

  task automatic waitPops(input int target, input int budget);
    int k = 0;
    while (pop_count < target && k < budget) begin
      stepCycle();
      k++;
    end
    checkVal("pop_wait_timeout", 64'(pop_count >= target), 64'd1);
  endtask

  task automatic applyStimulus(input vec_t v);
    int base_pops = pop_count;
    int base_acc  = accept_count;
    bus.out_ready = v.ready;
    check_pulse   = v.ready;
    for (int i = 0; i < v.n; i++) pushFifo(MEMORY_WIDTH'(v.first + i));
    runCycles(2 * v.n + 20);
    checkVal("vec_pops", 64'(pop_count - base_pops), 64'(v.exp_pops));
    checkVal("vec_words", 64'(accept_count - base_acc), 64'(v.exp_words));
    checkVal("vec_valid", 64'(bus.out_valid), 64'(v.exp_valid));
  endtask

  initial begin
    vec_t vecs[4];
    int   base_pops;
    int   base_acc;
    exp_t e;

    vecs[0] = '{n: 8, first: 1, ready: 1'b1, exp_words: 2, exp_pops: 8, exp_valid: 1'b0};
    vecs[1] = '{n: 3, first: 1, ready: 1'b1, exp_words: 0, exp_pops: 3, exp_valid: 1'b0};
    vecs[2] = '{n: 1, first: 4, ready: 1'b1, exp_words: 1, exp_pops: 1, exp_valid: 1'b0};
    vecs[3] = '{n: 4, first: 9, ready: 1'b1, exp_words: 1, exp_pops: 4, exp_valid: 1'b0};

    rrst_n        = 1'b0;
    bus.r_empty   = 1'b1;
    bus.rdata     = '0;
    bus.out_ready = 1'b0;
`ifdef FIFO_RD_PACKER_FLUSH_EN
    bus.flush     = 1'b0;
`endif
    runCycles(3);
    rrst_n = 1'b1;
    checkVal("reset_out_valid", 64'(bus.out_valid), 64'd0);
    checkVal("reset_out_data", 64'(bus.out_data), 64'd0);
    checkVal("reset_r_en", 64'(bus.r_en), 64'd0);

    $display("[TB] table-driven vectors");
    for (int i = 0; i < 4; i++) applyStimulus(vecs[i]);

    $display("[TB] backpressure");
    check_pulse   = 1'b0;
    bus.out_ready = 1'b0;
    base_pops     = pop_count;
    base_acc      = accept_count;
    for (int i = 1; i <= 12; i++) pushFifo(MEMORY_WIDTH'(i));
    runCycles(40);
    checkVal("stall_pops", 64'(pop_count - base_pops), 64'd8);
    checkVal("stall_words", 64'(accept_count - base_acc), 64'd0);
    checkVal("stall_valid", 64'(bus.out_valid), 64'd1);
    checkVal("stall_fifo_nonempty", 64'(bus.r_empty), 64'd0);
    checkVal("stall_r_en", 64'(bus.r_en), 64'd0);
    bus.out_ready = 1'b1;
    runCycles(30);
    checkVal("release_words", 64'(accept_count - base_acc), 64'd3);
    checkVal("release_pops", 64'(pop_count - base_pops), 64'd12);

    $display("[TB] reset mid-word");
    check_pulse = 1'b1;
    base_pops   = pop_count;
    base_acc    = accept_count;
    for (int i = 1; i <= 6; i++) pushFifo(MEMORY_WIDTH'(i));
    waitPops(base_pops + 5, 40);
    checkVal("pre_reset_backlog", 64'(exp_q.size()), 64'd0);
    rrst_n = 1'b0;
    @(negedge r_clk);
    checkVal("reset_r_en_forced", 64'(bus.r_en), 64'd0);
    @(posedge r_clk);
    #1;
    cyc++;
    rrst_n = 1'b1;
    fifo_q.delete();
    bus.r_empty = 1'b1;
    nib_buf     = '0;
    nib_cnt     = 0;
    checkVal("midreset_out_valid", 64'(bus.out_valid), 64'd0);
    checkVal("midreset_out_data", 64'(bus.out_data), 64'd0);
    for (int i = 9; i <= 12; i++) pushFifo(MEMORY_WIDTH'(i));
    runCycles(20);
    checkVal("post_reset_words", 64'(accept_count - base_acc), 64'd2);

    $display("[TB] sustained throughput");
    accept_cycles.delete();
    base_pops = pop_count;
    base_acc  = accept_count;
    for (int i = 0; i < 64; i++) pushFifo(MEMORY_WIDTH'(i % 16));
    runCycles(120);
    checkVal("stream_pops", 64'(pop_count - base_pops), 64'd64);
    checkVal("stream_words", 64'(accept_count - base_acc), 64'd16);
    checkVal("stream_backlog", 64'(exp_q.size()), 64'd0);
    for (int i = 1; i < accept_cycles.size(); i++) begin
      checkVal("stream_interval", 64'(accept_cycles[i] - accept_cycles[i-1]), 64'(PACK_RATIO + 1));
    end

`ifdef FIFO_RD_PACKER_FLUSH_EN
    $display("[TB] flush");
    base_acc = accept_count;
    pushFifo(MEMORY_WIDTH'(5));
    pushFifo(MEMORY_WIDTH'(6));
    runCycles(6);
    e.data = nib_buf;
    e.cnt  = nib_cnt;
    exp_q.push_back(e);
    nib_buf   = '0;
    nib_cnt   = 0;
    bus.flush = 1'b1;
    stepCycle();
    bus.flush = 1'b0;
    runCycles(10);
    checkVal("flush_words", 64'(accept_count - base_acc), 64'd1);
    checkVal("flush_expected_word", 64'(e.data), 64'h0065);
    base_acc  = accept_count;
    bus.flush = 1'b1;
    stepCycle();
    bus.flush = 1'b0;
    runCycles(10);
    checkVal("flush_empty_words", 64'(accept_count - base_acc), 64'd0);
`else
    $display("[TB] partial word retained");
    base_acc = accept_count;
    pushFifo(MEMORY_WIDTH'(5));
    pushFifo(MEMORY_WIDTH'(6));
    runCycles(20);
    checkVal("partial_words", 64'(accept_count - base_acc), 64'd0);
    checkVal("partial_valid", 64'(bus.out_valid), 64'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
